rx_merge2: RTL and testbench



---
 rtl/rx_merge2_pkg.sv | 8 +
 rtl/skid2x9.sv | 45 ++++
 rtl/rx_merge2.sv | 137 +++++++++++++
 tb/tb_rx_merge2.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/rx_merge2_pkg.sv
// Shared definitions for the two-port RX merge: word layout, FSM states, gap word.
package rx_merge2_pkg;
   localparam int         WORD_W   = 9;
   localparam int         VLD_BIT  = 8;
   localparam logic [8:0] GAP_WORD = 9'h000;

   typedef enum logic [2:0] {IDLE, HUNT, FWD, DROP, GAP} state_t;
endpackage

// File: rtl/skid2x9.sv
// Two-entry skid FIFO between the merge FSM and the TX queue; head is always ent0.
module skid2x9
   import rx_merge2_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic [WORD_W-1:0] din,
   input  logic              pop,
   output logic [WORD_W-1:0] head,
   output logic [1:0]        occ
);
   logic [WORD_W-1:0] ent0, ent1;

   assign head = ent0;

   // Upstream credit guarantees no push while full and no pop while empty.
   always_ff @(posedge clk) begin
      if (rst) begin
         ent0 <= '0;
         ent1 <= '0;
         occ  <= 2'd0;
      end else begin
         case ({push, pop})
            2'b10: begin
               if (occ == 2'd0) ent0 <= din;
               else             ent1 <= din;
               occ <= occ + 2'd1;
            end
            2'b01: begin
               ent0 <= ent1;
               occ  <= occ - 2'd1;
            end
            2'b11: begin
               if (occ == 2'd1) ent0 <= din;
               else begin
                  ent0 <= ent1;
                  ent1 <= din;
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: rtl/rx_merge2.sv
// Frame-atomic round-robin merge of two 9-bit RX queues into one TX queue,
// with gap stripping/regeneration, MaxLen truncation and per-port frame counters.
module rx_merge2
   import rx_merge2_pkg::*;
#(
   parameter logic [3:0]  Gap    = 4'h8,
   parameter logic [11:0] MaxLen = 12'd1522
) (
   input  logic        sys_clk,
   input  logic        sys_rst,
   input  logic [8:0]  port0rx_dout,
   input  logic        port0rx_empty,
   output logic        port0rx_rd_en,
   input  logic [8:0]  port1rx_dout,
   input  logic        port1rx_empty,
   output logic        port1rx_rd_en,
   output logic [8:0]  tx_din,
   input  logic        tx_full,
   output logic        tx_wr_en,
   output logic [31:0] port0_frames,
   output logic [31:0] port1_frames,
   output logic [15:0] trunc_frames
);
   state_t      state, state_nx;
   logic        sel, sel_nx, rr, rd_en, rd_en_q;
   logic        push, pop, credit_ok, sel_empty;
   logic        len_ld, len_inc, frame_done, trunc, gap_step;
   logic [8:0]  rx_word, push_data;
   logic [1:0]  occ;
   logic [2:0]  occ_proj;
   logic [11:0] len;
   logic [3:0]  gap_cnt;

   skid2x9 u_skid (
      .clk  (sys_clk),
      .rst  (sys_rst),
      .push (push),
      .din  (push_data),
      .pop  (pop),
      .head (tx_din),
      .occ  (occ)
   );

   assign pop       = (occ != 2'd0) & ~tx_full;
   assign tx_wr_en  = pop;
   // Occupancy after this cycle's pop and the pending push of last cycle's read.
   assign occ_proj  = {1'b0, occ} + {2'b00, rd_en_q} - {2'b00, pop};
   assign credit_ok = (occ_proj <= 3'd1);
   assign rx_word   = sel ? port1rx_dout : port0rx_dout;
   assign sel_empty = sel ? port1rx_empty : port0rx_empty;
   assign port0rx_rd_en = rd_en & ~sel;
   assign port1rx_rd_en = rd_en & sel;

   always_comb begin
      state_nx   = state;
      sel_nx     = sel;
      rd_en      = 1'b0;
      push       = 1'b0;
      push_data  = rx_word;
      len_ld     = 1'b0;
      len_inc    = 1'b0;
      frame_done = 1'b0;
      trunc      = 1'b0;
      gap_step   = 1'b0;
      case (state)
         IDLE: if (~port0rx_empty | ~port1rx_empty) begin
            sel_nx   = (~port0rx_empty & ~port1rx_empty) ? rr : port0rx_empty;
            state_nx = HUNT;
         end
         HUNT: begin
            rd_en = ~sel_empty & credit_ok;
            if (rd_en_q & rx_word[VLD_BIT]) begin
               push     = 1'b1;
               len_ld   = 1'b1;
               state_nx = FWD;
            end else if (~rd_en_q & sel_empty) begin
               state_nx = IDLE;
            end
         end
         FWD: begin
            rd_en = ~sel_empty & credit_ok;
            if (rd_en_q) begin
               if (~rx_word[VLD_BIT]) begin
                  frame_done = 1'b1;
                  state_nx   = GAP;
               end else if (len == MaxLen) begin
                  frame_done = 1'b1;
                  trunc      = 1'b1;
                  state_nx   = DROP;
               end else begin
                  push    = 1'b1;
                  len_inc = 1'b1;
               end
            end
         end
         DROP: begin
            rd_en = ~sel_empty & credit_ok;
            if (rd_en_q & ~rx_word[VLD_BIT]) state_nx = GAP;
         end
         GAP: if (credit_ok) begin
            push      = 1'b1;
            push_data = GAP_WORD;
            gap_step  = 1'b1;
            if (gap_cnt == Gap - 4'd1) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state        <= IDLE;
         sel          <= 1'b0;
         rr           <= 1'b0;
         rd_en_q      <= 1'b0;
         len          <= 12'd0;
         gap_cnt      <= 4'd0;
         port0_frames <= 32'd0;
         port1_frames <= 32'd0;
         trunc_frames <= 16'd0;
      end else begin
         state   <= state_nx;
         sel     <= sel_nx;
         rd_en_q <= rd_en;
         if (len_ld)       len <= 12'd1;
         else if (len_inc) len <= len + 12'd1;
         if (state != GAP)  gap_cnt <= 4'd0;
         else if (gap_step) gap_cnt <= gap_cnt + 4'd1;
         if (state == GAP && state_nx == IDLE) rr <= ~rr;
         if (frame_done) begin
            if (sel) port1_frames <= port1_frames + 32'd1;
            else     port0_frames <= port0_frames + 32'd1;
         end
         if (trunc) trunc_frames <= trunc_frames + 16'd1;
      end
   end
endmodule

// File: tb/tb_rx_merge2.sv
// Randomized bench for rx_merge2: RX queues modelled as arrays, expected TX stream built per frame.
module tb_rx_merge2;
   localparam int GAP_N  = 8;
   localparam int MAXLEN = 1522;

   logic        sys_clk = 1'b0;
   logic        sys_rst = 1'b1;
   logic [8:0]  port0rx_dout = '0;
   logic [8:0]  port1rx_dout = '0;
   logic        port0rx_empty, port1rx_empty, port0rx_rd_en, port1rx_rd_en;
   logic [8:0]  tx_din;
   logic        tx_full = 1'b0;
   logic        tx_wr_en;
   logic [31:0] port0_frames, port1_frames;
   logic [15:0] trunc_frames;

   rx_merge2 dut (
      .sys_clk       (sys_clk),
      .sys_rst       (sys_rst),
      .port0rx_dout  (port0rx_dout),
      .port0rx_empty (port0rx_empty),
      .port0rx_rd_en (port0rx_rd_en),
      .port1rx_dout  (port1rx_dout),
      .port1rx_empty (port1rx_empty),
      .port1rx_rd_en (port1rx_rd_en),
      .tx_din        (tx_din),
      .tx_full       (tx_full),
      .tx_wr_en      (tx_wr_en),
      .port0_frames  (port0_frames),
      .port1_frames  (port1_frames),
      .trunc_frames  (trunc_frames)
   );

   always #5 sys_clk = ~sys_clk;

   // RX queues: contents written by the stimulus, read pointer advanced on rd_en.
   logic [8:0] q0[$], q1[$];
   int wr0 = 0, wr1 = 0, rd0 = 0, rd1 = 0;
   assign port0rx_empty = (rd0 >= wr0);
   assign port1rx_empty = (rd1 >= wr1);

   always @(posedge sys_clk) begin
      if (sys_rst) begin
         rd0 <= wr0;
         rd1 <= wr1;
      end else begin
         if (port0rx_rd_en) begin port0rx_dout <= q0[rd0]; rd0 <= rd0 + 1; end
         if (port1rx_rd_en) begin port1rx_dout <= q1[rd1]; rd1 <= rd1 + 1; end
      end
   end

   int cyc = 0;
   always @(posedge sys_clk) cyc <= cyc + 1;

   logic [8:0] outq[$], expq[$];
   int first_rd = -1, first_wr = -1, viol = 0, max_occ = 0;
   always @(negedge sys_clk) if (!sys_rst) begin
      if (tx_wr_en) outq.push_back(tx_din);
      if (port0rx_rd_en && first_rd < 0) first_rd = cyc;
      if (tx_wr_en && first_wr < 0) first_wr = cyc;
      if ((port0rx_rd_en && port0rx_empty) || (port1rx_rd_en && port1rx_empty) ||
          (port0rx_rd_en && port1rx_rd_en)) viol++;
      if (int'(dut.occ) > max_occ) max_occ = int'(dut.occ);
   end

   bit rand_full = 1'b0;
   initial forever begin
      @(posedge sys_clk); #1;
      tx_full = rand_full ? 1'($urandom_range(0, 1)) : 1'b0;
   end

   int checks = 0, errors = 0;
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) begin @(posedge sys_clk); #1; end
   endtask

   task automatic push_rx(input int port, input logic [8:0] w);
      if (port == 0) begin q0.push_back(w); wr0++; end
      else           begin q1.push_back(w); wr1++; end
   endtask

   // A frame goes out truncated to MAXLEN and followed by GAP_N zero words.
   task automatic put_frame(input int port, input int len);
      logic [8:0] w;
      for (int i = 0; i < len; i++) begin
         w = {1'b1, 8'($urandom)};
         push_rx(port, w);
         if (i < MAXLEN) expq.push_back(w);
      end
      push_rx(port, 9'h000);
      push_rx(port, 9'h000);
      for (int i = 0; i < GAP_N; i++) expq.push_back(9'h000);
   endtask

   task automatic run_check(input string tag, input int budget);
      int n = 0;
      int k;
      while (outq.size() < expq.size() && n < budget) begin tick(); n++; end
      tick(30);
      chk({tag, "_len"}, 64'(outq.size()), 64'(expq.size()));
      if (outq.size() > 0 && expq.size() > 0) begin
         k = (outq.size() < expq.size() ? outq.size() : expq.size()) - 1;
         for (int i = 0; i <= k; i++)
            if (outq[i] !== expq[i]) begin k = i; break; end
         chk({tag, "_data"}, 64'(outq[k]), 64'(expq[k]));
      end
   endtask

   task automatic do_reset();
      sys_rst = 1'b1;
      tick(2);
      sys_rst = 1'b0;
      outq.delete();
      expq.delete();
      first_rd = -1;
      first_wr = -1;
      max_occ  = 0;
   endtask

   initial begin
      int n;
      do_reset();
      chk("rst_rd0", 64'(port0rx_rd_en), 64'd0);
      chk("rst_rd1", 64'(port1rx_rd_en), 64'd0);
      chk("rst_wr", 64'(tx_wr_en), 64'd0);
      chk("rst_din", 64'(tx_din), 64'd0);
      chk("rst_p0", 64'(port0_frames), 64'd0);
      chk("rst_p1", 64'(port1_frames), 64'd0);
      chk("rst_trunc", 64'(trunc_frames), 64'd0);

      // single frame, latency
      put_frame(0, 64);
      run_check("t1", 2000);
      chk("t1_p0", 64'(port0_frames), 64'd1);
      chk("t1_latency", 64'(first_wr - first_rd), 64'd2);

      // round robin with both queues loaded
      do_reset();
      for (int f = 0; f < 3; f++) begin
         put_frame(0, 60);
         put_frame(1, 100);
      end
      run_check("t2", 5000);
      chk("t2_p0", 64'(port0_frames), 64'd3);
      chk("t2_p1", 64'(port1_frames), 64'd3);

      // backpressure
      do_reset();
      rand_full = 1'b1;
      put_frame(0, 1500);
      run_check("t3", 20000);
      rand_full = 1'b0;
      chk("t3_occ_le2", 64'(max_occ <= 2), 64'd1);
      chk("t3_p0", 64'(port0_frames), 64'd1);

      // truncation, then an intact frame
      do_reset();
      put_frame(0, 1600);
      put_frame(0, 50);
      run_check("t4", 10000);
      chk("t4_trunc", 64'(trunc_frames), 64'd1);
      chk("t4_p0", 64'(port0_frames), 64'd2);

      // gap-only queue on port 1, frame on port 0 later
      do_reset();
      for (int i = 0; i < 5; i++) push_rx(1, 9'h000);
      tick(40);
      chk("t5_no_out", 64'(outq.size()), 64'd0);
      chk("t5_p1_drained", 64'(wr1 - rd1), 64'd0);
      put_frame(0, 30);
      run_check("t5", 2000);
      chk("t5_p0", 64'(port0_frames), 64'd1);
      chk("t5_p1", 64'(port1_frames), 64'd0);

      // reset mid-frame
      do_reset();
      put_frame(0, 200);
      n = 0;
      while (outq.size() < 50 && n < 1000) begin tick(); n++; end
      chk("t6_midframe", 64'(outq.size() >= 50), 64'd1);
      sys_rst = 1'b1;
      tick(1);
      sys_rst = 1'b0;
      chk("t6_rd0", 64'(port0rx_rd_en), 64'd0);
      chk("t6_wr", 64'(tx_wr_en), 64'd0);
      chk("t6_din", 64'(tx_din), 64'd0);
      chk("t6_p0_clr", 64'(port0_frames), 64'd0);
      outq.delete();
      expq.delete();
      put_frame(0, 40);
      run_check("t6", 2000);
      chk("t6_p0", 64'(port0_frames), 64'd1);

      chk("rd_en_rules", 64'(viol), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
